// File: rtl/reset_sequencer.sv
// Ordered multi-stage reset sequencer: holds every stage in reset, then releases them one at a time,
// waiting for each stage's ack. A missing ack times out and restarts the sequence.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned MIN_ASSERT  = 8,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_ready,
    output logic                  timeout_err,
    output logic [1:0]            rst_cause
);

    localparam int unsigned MAX_A   = (MIN_ASSERT > STAGE_DELAY) ? MIN_ASSERT : STAGE_DELAY;
    localparam int unsigned MAX_CNT = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [1:0] CausePowerOn = 2'd0;
    localparam logic [1:0] CauseSw      = 2'd1;
    localparam logic [1:0] CauseTimeout = 2'd2;

    typedef enum logic [1:0] {
        StHold,
        StWaitAck,
        StDelay,
        StRun
    } state_e;

    state_e                r_state, w_state_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d;
    logic [IDX_W-1:0]      r_idx, w_idx_d;
    logic [NUM_STAGES-1:0] r_stage_rst, w_stage_rst_d;
    logic                  r_all_ready, w_all_ready_d;
    logic                  r_timeout_err, w_timeout_err_d;
    logic [1:0]            r_rst_cause, w_rst_cause_d;

    logic                  w_ack;
    logic [IDX_W-1:0]      w_idx_inc;

    assign w_ack     = stage_ack[r_idx];
    assign w_idx_inc = r_idx + IDX_W'(1);

    always_comb begin
        w_state_d       = r_state;
        w_cnt_d         = r_cnt;
        w_idx_d         = r_idx;
        w_stage_rst_d   = r_stage_rst;
        w_all_ready_d   = r_all_ready;
        w_timeout_err_d = r_timeout_err;
        w_rst_cause_d   = r_rst_cause;

        // Software request beats any ack or timeout seen in the same cycle.
        if (sw_rst_req) begin
            w_state_d     = StHold;
            w_cnt_d       = '0;
            w_idx_d       = '0;
            w_stage_rst_d = '1;
            w_all_ready_d = 1'b0;
            w_rst_cause_d = CauseSw;
        end else begin
            unique case (r_state)
                StHold: begin
                    w_stage_rst_d = '1;
                    w_all_ready_d = 1'b0;
                    if (r_cnt == CNT_W'(MIN_ASSERT - 1)) begin
                        w_state_d        = StWaitAck;
                        w_cnt_d          = '0;
                        w_idx_d          = '0;
                        w_stage_rst_d[0] = 1'b0;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                StWaitAck: begin
                    if (w_ack) begin
                        w_cnt_d = '0;
                        if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
                            w_state_d     = StRun;
                            w_all_ready_d = 1'b1;
                        end else begin
                            w_state_d = StDelay;
                        end
                    end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        w_state_d       = StHold;
                        w_cnt_d         = '0;
                        w_idx_d         = '0;
                        w_stage_rst_d   = '1;
                        w_timeout_err_d = 1'b1;
                        w_rst_cause_d   = CauseTimeout;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                StDelay: begin
                    if (r_cnt == CNT_W'(STAGE_DELAY - 1)) begin
                        w_state_d = StWaitAck;
                        w_cnt_d   = '0;
                        w_idx_d   = w_idx_inc;
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (w_idx_inc == IDX_W'(i)) begin
                                w_stage_rst_d[i] = 1'b0;
                            end
                        end
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                StRun: begin
                    w_all_ready_d = 1'b1;
                end
                default: begin
                    w_state_d = StHold;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state       <= StHold;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stage_rst   <= '1;
            r_all_ready   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rst_cause   <= CausePowerOn;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_idx         <= w_idx_d;
            r_stage_rst   <= w_stage_rst_d;
            r_all_ready   <= w_all_ready_d;
            r_timeout_err <= w_timeout_err_d;
            r_rst_cause   <= w_rst_cause_d;
        end
    end

    assign stage_rst   = r_stage_rst;
    assign all_ready   = r_all_ready;
    assign timeout_err = r_timeout_err;
    assign rst_cause   = r_rst_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a vector table for the nominal flow plus hand-written
// sequences for timeout, ack-on-last-cycle, async reset and a single-stage build.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       arst;
    logic       sw_rst_req;
    logic [2:0] stage_ack;
    logic [2:0] stage_rst;
    logic       all_ready;
    logic       timeout_err;
    logic [1:0] rst_cause;

    logic       sw1;
    logic [0:0] ack1;
    logic [0:0] rst1;
    logic       ready1;
    logic       to1;
    logic [1:0] cause1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer u_dut (
        .clk         (clk),
        .arst        (arst),
        .sw_rst_req  (sw_rst_req),
        .stage_ack   (stage_ack),
        .stage_rst   (stage_rst),
        .all_ready   (all_ready),
        .timeout_err (timeout_err),
        .rst_cause   (rst_cause)
    );

    reset_sequencer #(
        .NUM_STAGES (1)
    ) u_dut1 (
        .clk         (clk),
        .arst        (arst),
        .sw_rst_req  (sw1),
        .stage_ack   (ack1),
        .stage_rst   (rst1),
        .all_ready   (ready1),
        .timeout_err (to1),
        .rst_cause   (cause1)
    );

    typedef struct {
        string       name;
        int unsigned cycles;
        logic        sw;
        logic [2:0]  ack;
        logic [2:0]  exp_rst;
        logic        exp_ready;
        logic        exp_to;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [2:0] er, input logic ey,
                           input logic et, input logic [1:0] ec);
        chk({name, ".stage_rst"}, 32'(stage_rst), 32'(er));
        chk({name, ".all_ready"}, 32'(all_ready), 32'(ey));
        chk({name, ".timeout_err"}, 32'(timeout_err), 32'(et));
        chk({name, ".rst_cause"}, 32'(rst_cause), 32'(ec));
    endtask

    initial begin
        arst       = 1'b0;
        sw_rst_req = 1'b0;
        stage_ack  = 3'b000;
        sw1        = 1'b0;
        ack1       = 1'b0;

        // Nominal flow with acks tied high, then sw pulse, sw held in DELAY, sw+ack collision.
        vecs.push_back('{"hold7",      7,  1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{"rel0",       1,  1'b0, 3'b111, 3'b110, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{"gap0",       16, 1'b0, 3'b111, 3'b110, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{"rel1",       1,  1'b0, 3'b111, 3'b100, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{"gap1",       16, 1'b0, 3'b111, 3'b100, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{"rel2",       1,  1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{"run",        1,  1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{"ack_drop",   5,  1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{"sw_pulse",   1,  1'b1, 3'b000, 3'b111, 1'b0, 1'b0, 2'd1});
        vecs.push_back('{"sw_hold7",   7,  1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 2'd1});
        vecs.push_back('{"sw_rel0",    1,  1'b0, 3'b111, 3'b110, 1'b0, 1'b0, 2'd1});
        vecs.push_back('{"in_delay",   3,  1'b0, 3'b111, 3'b110, 1'b0, 1'b0, 2'd1});
        vecs.push_back('{"sw_held20",  20, 1'b1, 3'b111, 3'b111, 1'b0, 1'b0, 2'd1});
        vecs.push_back('{"after20_7",  7,  1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 2'd1});
        vecs.push_back('{"after20_8",  1,  1'b0, 3'b111, 3'b110, 1'b0, 1'b0, 2'd1});
        vecs.push_back('{"sw_and_ack", 1,  1'b1, 3'b111, 3'b111, 1'b0, 1'b0, 2'd1});
        vecs.push_back('{"coll_rel0",  8,  1'b0, 3'b111, 3'b110, 1'b0, 1'b0, 2'd1});
        vecs.push_back('{"coll_run",   35, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 2'd1});

        tick(2);
        chk_all("reset", 3'b111, 1'b0, 1'b0, 2'd0);
        chk("reset1.stage_rst", 32'(rst1), 32'd1);

        arst      = 1'b1;
        stage_ack = 3'b111;
        foreach (vecs[k]) begin
            sw_rst_req = vecs[k].sw;
            stage_ack  = vecs[k].ack;
            tick(vecs[k].cycles);
            chk_all(vecs[k].name, vecs[k].exp_rst, vecs[k].exp_ready, vecs[k].exp_to,
                    vecs[k].exp_cause);
        end

        // Ack arriving on the last allowed WAIT_ACK cycle must still proceed.
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        stage_ack  = 3'b001;
        tick(8);
        chk_all("late.rel0", 3'b110, 1'b0, 1'b0, 2'd1);
        tick(17);
        chk_all("late.rel1", 3'b100, 1'b0, 1'b0, 2'd1);
        tick(254);
        chk_all("late.c254", 3'b100, 1'b0, 1'b0, 2'd1);
        stage_ack = 3'b111;
        tick(1);
        chk_all("late.c255", 3'b100, 1'b0, 1'b0, 2'd1);
        tick(16);
        chk_all("late.rel2", 3'b000, 1'b0, 1'b0, 2'd1);
        tick(1);
        chk_all("late.run", 3'b000, 1'b1, 1'b0, 2'd1);

        // Stage 1 never acks: timeout, then a retry that completes.
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        stage_ack  = 3'b001;
        tick(25);
        chk_all("to.rel1", 3'b100, 1'b0, 1'b0, 2'd1);
        tick(254);
        chk_all("to.c254", 3'b100, 1'b0, 1'b0, 2'd1);
        tick(1);
        chk_all("to.fire", 3'b111, 1'b0, 1'b1, 2'd2);
        stage_ack = 3'b111;
        tick(8);
        chk_all("to.retry0", 3'b110, 1'b0, 1'b1, 2'd2);
        tick(35);
        chk_all("to.retryrun", 3'b000, 1'b1, 1'b1, 2'd2);

        // Park in WAIT_ACK idx 2, then pulse arst between clock edges.
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        stage_ack  = 3'b011;
        tick(42);
        chk_all("arst.pre", 3'b000, 1'b0, 1'b1, 2'd1);
        #2;
        arst = 1'b0;
        #1;
        chk_all("arst.async", 3'b111, 1'b0, 1'b0, 2'd0);
        chk("arst.rst1", 32'(rst1), 32'd1);
        chk("arst.to1", 32'(to1), 32'd0);
        tick(1);
        arst      = 1'b1;
        stage_ack = 3'b111;
        ack1      = 1'b1;
        tick(7);
        chk("one.hold.rst", 32'(rst1), 32'd1);
        tick(1);
        chk_all("arst.rel0", 3'b110, 1'b0, 1'b0, 2'd0);
        chk("one.rel.rst", 32'(rst1), 32'd0);
        chk("one.rel.ready", 32'(ready1), 32'd0);
        tick(1);
        chk("one.run.ready", 32'(ready1), 32'd1);
        chk("one.run.cause", 32'(cause1), 32'd0);
        chk("one.run.to", 32'(to1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of ordered reset stages (1..8).
REQ-002 SHALL have parameter MIN_ASSERT, default 8, cycles all stages are held in reset before sequencing (>=1).
REQ-003 SHALL have parameter STAGE_DELAY, default 16, gap cycles between a stage's ack and the next stage's release (>=1).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 255, max cycles to wait for a stage ack (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port arst  input  1  reset, asynchronous, active-low; upstream guarantees deassertion is synchronous to clk.
REQ-007 SHALL have port sw_rst_req  input  1  synchronous active-high software reset request, sampled every cycle.
REQ-008 SHALL have port stage_ack  input  NUM_STAGES  bit i high = stage i finished its init after release.
REQ-009 SHALL have port stage_rst  output  NUM_STAGES  registered active-high synchronous reset per stage.
REQ-010 SHALL have port all_ready  output  1  registered; high only when every stage is released and acked.
REQ-011 SHALL have port timeout_err  output  1  registered sticky flag; a stage ack timed out.
REQ-012 SHALL have port rst_cause  output  2  registered cause of the last sequence: 0 power-on, 1 software, 2 ack timeout, 3 reserved.

Function
REQ-013 SHALL implement FSM states HOLD, WAIT_ACK, DELAY, RUN, plus stage index idx ($clog2(NUM_STAGES) bits, min 1) and one shared cycle counter sized for max(MIN_ASSERT, STAGE_DELAY, ACK_TIMEOUT).
REQ-014 HOLD: all stage_rst = 1, all_ready = 0, counter increments; after exactly MIN_ASSERT cycles in HOLD -> WAIT_ACK with idx = 0, counter = 0, stage_rst[0] cleared on that same edge.
REQ-015 WAIT_ACK: counter increments; stage_ack[idx] = 1 -> if idx = NUM_STAGES-1 go RUN, else go DELAY with counter = 0.
REQ-016 WAIT_ACK: ACK_TIMEOUT cycles without stage_ack[idx] -> HOLD, counter = 0, timeout_err set, rst_cause = 2, all stage_rst re-asserted on that edge.
REQ-017 Ack and timeout in the same cycle: ack wins.
REQ-018 DELAY: counter increments; after exactly STAGE_DELAY cycles -> WAIT_ACK, idx + 1, counter = 0, stage_rst[idx+1] cleared on that edge.
REQ-019 Stage release strictly ordered: stage_rst[j] SHALL never be 0 while stage_rst[i] = 1 for any i < j.
REQ-020 Entry to RUN: all_ready = 1 from the edge of the final ack onward; RUN holds until sw_rst_req.
REQ-021 sw_rst_req = 1 in any state -> HOLD on the next edge: counter = 0, idx = 0, all stage_rst = 1, all_ready = 0, rst_cause = 1; overrides ack/timeout in the same cycle.
REQ-022 sw_rst_req held high SHALL keep the FSM in HOLD with counter at 0; MIN_ASSERT counting starts on the first cycle it is low.
REQ-023 stage_ack bits other than stage_ack[idx] in WAIT_ACK SHALL be ignored, including drops of acked stages in RUN.
REQ-024 timeout_err SHALL clear only on arst; unlimited retry sequences allowed.
REQ-025 Only the WAIT_ACK timeout path and sw_rst_req SHALL modify rst_cause after reset.

Reset
REQ-026 While arst = 0: state HOLD, counter 0, idx 0, stage_rst all 1, all_ready 0, timeout_err 0, rst_cause 0, asynchronously.
REQ-027 arst assertion mid-sequence (any state) SHALL immediately re-assert all stage_rst and restart from HOLD on release.
REQ-028 No output SHALL glitch low on stage_rst during arst assertion or between stages.

Verification
REQ-029 Defaults, stage_ack tied high after release: arst release -> stage_rst[0] low after edge 8, [1] after 8+1+16+... each gap = 1 ack cycle + 16; all_ready high after final ack; rst_cause = 0.
REQ-030 stage_ack[1] never asserted -> after 255 cycles in WAIT_ACK all stage_rst = 3'b111, timeout_err = 1, rst_cause = 2, sequence restarts; then ack -> RUN with timeout_err still 1.
REQ-031 sw_rst_req 1-cycle pulse in RUN -> next edge stage_rst = 3'b111, all_ready = 0, rst_cause = 1; full resequence follows.
REQ-032 sw_rst_req held 20 cycles during DELAY -> stays HOLD 20 cycles, then 8 more before stage_rst[0] releases.
REQ-033 stage_ack[idx] and sw_rst_req same cycle -> HOLD, rst_cause = 1; ack on exactly cycle 255 -> proceeds, no timeout_err.
REQ-034 arst pulsed low during WAIT_ACK idx = 2 -> stage_rst = 3'b111 asynchronously, all flags/cause cleared; NUM_STAGES = 1 build completes with single release.
